// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU port: widths, port selects, FSM states, queued op.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vdp_pkg;

    localparam int VRAM_AW = 14;

    localparam logic PORT_DATA = 1'b0;
    localparam logic PORT_CTRL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAP  = 2'd2
    } vdp_state_t;

    // One VRAM access as captured at the host event.
    typedef struct packed {
        logic               wr;
        logic [VRAM_AW-1:0] addr;
        logic [7:0]         data;
    } vdp_op_t;

endpackage

// File: rtl/vdp_cpu_decode.sv
// Control-port two-byte latch: decodes register writes and VRAM address loads.
// Latency: reg_* registered (1 cycle); addr_load/prefetch_req combinational with the 2nd byte.
// Backpressure: none; every control write is consumed in the cycle it arrives.
//
// Ports: clk40m/rst_n clock and reset; i_ctrl_wr control-port write strobe;
// i_clr clears the first-byte flag (any other host access); i_din host byte;
// o_reg_we/o_reg_num/o_reg_data register write; o_addr_load/o_addr/o_prefetch_req
// pointer load and read-setup indication.
module vdp_cpu_decode
    import vdp_pkg::*;
(
    input  logic               clk40m,
    input  logic               rst_n,
    input  logic               i_ctrl_wr,
    input  logic               i_clr,
    input  logic [7:0]         i_din,
    output logic               o_reg_we,
    output logic [2:0]         o_reg_num,
    output logic [7:0]         o_reg_data,
    output logic               o_addr_load,
    output logic [VRAM_AW-1:0] o_addr,
    output logic               o_prefetch_req
);

    logic       r_flag;
    logic [7:0] r_byte1;
    logic       w_second;

    assign w_second       = i_ctrl_wr & r_flag;
    assign o_addr_load    = w_second & ~i_din[7];
    // Bit 6 clear means read setup: the new address is fetched ahead.
    assign o_prefetch_req = o_addr_load & ~i_din[6];
    assign o_addr         = {i_din[5:0], r_byte1};

    always_ff @(posedge clk40m or negedge rst_n) begin
        if (!rst_n) begin
            r_flag     <= 1'b0;
            r_byte1    <= 8'h00;
            o_reg_we   <= 1'b0;
            o_reg_num  <= 3'd0;
            o_reg_data <= 8'h00;
        end else begin
            o_reg_we <= w_second & i_din[7];
            if (w_second && i_din[7]) begin
                o_reg_num  <= i_din[2:0];
                o_reg_data <= r_byte1;
            end
            if (i_ctrl_wr) begin
                if (!r_flag) begin
                    r_byte1 <= i_din;
                    r_flag  <= 1'b1;
                end else begin
                    r_flag  <= 1'b0;
                end
            end else if (i_clr) begin
                r_flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vdp_cpu_port.sv
// Host-side port of the VDP: data/control decode, address pointer, read-ahead buffer, VRAM initiator.
// Latency: cpu_dout/status_rd/reg_we 1 cycle after strobe; vram_req 1 cycle after capture when idle.
// Backpressure: one access in flight plus one pending slot; further data-port ops drop with overrun.
//
// Ports: clk40m/rst_n; cpu_rd/cpu_wr/cpu_mode/cpu_din/cpu_dout host bus; status_in/status_rd
// status byte and read pulse; reg_we/reg_num/reg_data register write; vram_req/vram_wr/
// vram_addr/vram_wdata/vram_ack/vram_rdata SRAM controller handshake; overrun drop pulse.
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int                ADDR_W   = VRAM_AW,
    parameter logic [ADDR_W-1:0] RST_ADDR = '0
) (
    input  logic              clk40m,
    input  logic              rst_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              cpu_mode,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    input  logic [7:0]        status_in,
    output logic              status_rd,
    output logic              reg_we,
    output logic [2:0]        reg_num,
    output logic [7:0]        reg_data,
    output logic              vram_req,
    output logic              vram_wr,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    input  logic              vram_ack,
    input  logic [7:0]        vram_rdata,
    output logic              overrun
);

    vdp_state_t          r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [7:0]          r_rbuf;
    vdp_op_t             r_slot;
    logic                r_slot_vld;

    logic                w_ctrl_wr, w_data_wr, w_rd, w_ctrl_rd, w_data_rd;
    logic                w_addr_load, w_prefetch;
    logic [VRAM_AW-1:0]  w_dec_addr;
    logic                w_new_vld;
    vdp_op_t             w_new_op;
    logic                w_issue, w_slot_load, w_slot_clr, w_drop;
    vdp_op_t             w_issue_op;

    // Write wins when both strobes arrive together.
    assign w_ctrl_wr = cpu_wr & (cpu_mode == PORT_CTRL);
    assign w_data_wr = cpu_wr & (cpu_mode == PORT_DATA);
    assign w_rd      = cpu_rd & ~cpu_wr;
    assign w_ctrl_rd = w_rd & (cpu_mode == PORT_CTRL);
    assign w_data_rd = w_rd & (cpu_mode == PORT_DATA);

    vdp_cpu_decode u_decode (
        .clk40m         (clk40m),
        .rst_n          (rst_n),
        .i_ctrl_wr      (w_ctrl_wr),
        .i_clr          (w_ctrl_rd | w_data_wr | w_data_rd),
        .i_din          (cpu_din),
        .o_reg_we       (reg_we),
        .o_reg_num      (reg_num),
        .o_reg_data     (reg_data),
        .o_addr_load    (w_addr_load),
        .o_addr         (w_dec_addr),
        .o_prefetch_req (w_prefetch)
    );

    // Operation captured from this cycle's host event (at most one per cycle).
    always_comb begin
        w_new_vld     = w_data_wr | w_data_rd | w_prefetch;
        w_new_op.wr   = w_data_wr;
        w_new_op.addr = w_prefetch ? w_dec_addr : VRAM_AW'(r_ptr);
        w_new_op.data = w_data_wr ? cpu_din : 8'h00;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_issue_op  = r_slot;
        w_slot_load = 1'b0;
        w_slot_clr  = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                // Pending slot goes first; a new op then takes the freed slot.
                if (r_slot_vld) begin
                    w_issue     = 1'b1;
                    w_slot_clr  = 1'b1;
                    w_slot_load = w_new_vld;
                end else if (w_new_vld) begin
                    w_issue    = 1'b1;
                    w_issue_op = w_new_op;
                end
                if (w_issue) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (vram_ack) w_state_nxt = vram_wr ? IDLE : CAP;
            end
            CAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (r_state != IDLE && w_new_vld) begin
            w_slot_load = ~r_slot_vld;
            w_drop      = r_slot_vld;
        end
    end

    always_ff @(posedge clk40m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk40m or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= RST_ADDR;
            r_rbuf     <= 8'h00;
            r_slot     <= '0;
            r_slot_vld <= 1'b0;
            cpu_dout   <= 8'h00;
            status_rd  <= 1'b0;
            vram_req   <= 1'b0;
            vram_wr    <= 1'b0;
            vram_addr  <= RST_ADDR;
            vram_wdata <= 8'h00;
            overrun    <= 1'b0;
        end else begin
            status_rd <= w_ctrl_rd;
            overrun   <= w_drop;
            vram_req  <= w_issue;

            if (w_issue) begin
                vram_wr    <= w_issue_op.wr;
                vram_addr  <= ADDR_W'(w_issue_op.addr);
                vram_wdata <= w_issue_op.data;
            end

            if (w_slot_load) begin
                r_slot     <= w_new_op;
                r_slot_vld <= 1'b1;
            end else if (w_slot_clr) begin
                r_slot_vld <= 1'b0;
            end

            // Read setup leaves the pointer one past the prefetched byte.
            if (w_data_wr || w_data_rd) begin
                r_ptr <= r_ptr + ADDR_W'(1);
            end else if (w_addr_load) begin
                r_ptr <= w_prefetch ? ADDR_W'(w_dec_addr) + ADDR_W'(1)
                                    : ADDR_W'(w_dec_addr);
            end

            // A host write landing with CAP is the later event, so it wins.
            if (w_data_wr) begin
                r_rbuf <= cpu_din;
            end else if (r_state == CAP) begin
                r_rbuf <= vram_rdata;
            end

            if (w_ctrl_rd) begin
                cpu_dout <= status_in;
            end else if (w_data_rd) begin
                cpu_dout <= r_rbuf;
            end
        end
    end

endmodule

// File: tb/tb_vdp_cpu_port.sv
module tb_vdp_cpu_port;

    logic        clk40m = 1'b0;
    logic        rst_n  = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic        cpu_mode = 1'b0;
    logic [7:0]  cpu_din = 8'h00;
    logic [7:0]  cpu_dout;
    logic [7:0]  status_in = 8'h00;
    logic        status_rd;
    logic        reg_we;
    logic [2:0]  reg_num;
    logic [7:0]  reg_data;
    logic        vram_req;
    logic        vram_wr;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_ack = 1'b0;
    logic [7:0]  vram_rdata = 8'h00;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int ack_dly = 2;
    int ack_cnt = 0;
    logic [7:0] sram_rdata = 8'h00;
    logic found;

    always #5 clk40m = ~clk40m;

    vdp_cpu_port dut (
        .clk40m     (clk40m),
        .rst_n      (rst_n),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_mode   (cpu_mode),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .status_in  (status_in),
        .status_rd  (status_rd),
        .reg_we     (reg_we),
        .reg_num    (reg_num),
        .reg_data   (reg_data),
        .vram_req   (vram_req),
        .vram_wr    (vram_wr),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_ack   (vram_ack),
        .vram_rdata (vram_rdata),
        .overrun    (overrun)
    );

    // SRAM controller model: ack ack_dly cycles after a req, read data held from ack on.
    always @(negedge clk40m) begin
        vram_ack = 1'b0;
        if (ack_cnt > 0) begin
            ack_cnt = ack_cnt - 1;
            if (ack_cnt == 0) begin
                vram_ack   = 1'b1;
                vram_rdata = sram_rdata;
            end
        end
        if (vram_req) ack_cnt = ack_dly;
    end

    task automatic tick();
        @(posedge clk40m);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_wr(input logic mode, input logic [7:0] d);
        cpu_wr   = 1'b1;
        cpu_mode = mode;
        cpu_din  = d;
        tick();
        cpu_wr   = 1'b0;
    endtask

    task automatic host_rd(input logic mode);
        cpu_rd   = 1'b1;
        cpu_mode = mode;
        tick();
        cpu_rd   = 1'b0;
    endtask

    task automatic settle();
        repeat (8) tick();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_cpu_dout", 32'(cpu_dout), 32'h00);
        chk("rst_vram_req", 32'(vram_req), 32'h0);
        chk("rst_vram_addr", 32'(vram_addr), 32'h0000);
        chk("rst_reg_we", 32'(reg_we), 32'h0);
        chk("rst_status_rd", 32'(status_rd), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        tick();

        // Register write: 0x07 then 0x81 -> R1 = 0x07
        host_wr(1'b1, 8'h07);
        chk("reg_we_first_byte", 32'(reg_we), 32'h0);
        host_wr(1'b1, 8'h81);
        chk("reg_we", 32'(reg_we), 32'h1);
        chk("reg_num", 32'(reg_num), 32'h1);
        chk("reg_data", 32'(reg_data), 32'h07);
        chk("reg_no_vram_req", 32'(vram_req), 32'h0);
        tick();
        chk("reg_we_pulse_end", 32'(reg_we), 32'h0);

        // Write setup 0x1234, then data write 0xAB
        host_wr(1'b1, 8'h34);
        host_wr(1'b1, 8'h52);
        chk("wsetup_no_req", 32'(vram_req), 32'h0);
        host_wr(1'b0, 8'hAB);
        chk("dw_req", 32'(vram_req), 32'h1);
        chk("dw_wr", 32'(vram_wr), 32'h1);
        chk("dw_addr", 32'(vram_addr), 32'h1234);
        chk("dw_wdata", 32'(vram_wdata), 32'hAB);
        tick();
        chk("dw_req_pulse_end", 32'(vram_req), 32'h0);
        chk("dw_addr_held", 32'(vram_addr), 32'h1234);
        settle();
        host_wr(1'b0, 8'hCD);
        chk("dw2_addr_incr", 32'(vram_addr), 32'h1235);
        settle();

        // Read setup 0x1000 with prefetch, SRAM returns 0x5A
        sram_rdata = 8'h5A;
        host_wr(1'b1, 8'h00);
        host_wr(1'b1, 8'h10);
        chk("pf_req", 32'(vram_req), 32'h1);
        chk("pf_wr", 32'(vram_wr), 32'h0);
        chk("pf_addr", 32'(vram_addr), 32'h1000);
        settle();
        host_rd(1'b0);
        chk("dr_dout", 32'(cpu_dout), 32'h5A);
        chk("dr_req", 32'(vram_req), 32'h1);
        chk("dr_wr", 32'(vram_wr), 32'h0);
        chk("dr_addr", 32'(vram_addr), 32'h1001);
        settle();

        // Pointer wrap: write setup 0x3FFF
        host_wr(1'b1, 8'hFF);
        host_wr(1'b1, 8'h7F);
        host_wr(1'b0, 8'h11);
        chk("wrap_addr_top", 32'(vram_addr), 32'h3FFF);
        settle();
        host_wr(1'b0, 8'h22);
        chk("wrap_addr_zero", 32'(vram_addr), 32'h0000);
        settle();

        // Overrun: three back-to-back writes from 0x0100, ack after 3 cycles
        ack_dly = 3;
        host_wr(1'b1, 8'h00);
        host_wr(1'b1, 8'h41);
        host_wr(1'b0, 8'h01);
        chk("ovr_first_addr", 32'(vram_addr), 32'h0100);
        host_wr(1'b0, 8'h02);
        chk("ovr_slot_no_overrun", 32'(overrun), 32'h0);
        host_wr(1'b0, 8'h03);
        chk("ovr_pulse", 32'(overrun), 32'h1);
        tick();
        chk("ovr_pulse_end", 32'(overrun), 32'h0);
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (vram_req) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("ovr_slot_issued", 32'(found), 32'h1);
        chk("ovr_slot_addr", 32'(vram_addr), 32'h0101);
        chk("ovr_slot_wdata", 32'(vram_wdata), 32'h02);
        settle();
        host_wr(1'b0, 8'h04);
        chk("ovr_ptr_adv3", 32'(vram_addr), 32'h0103);
        chk("ovr_next_wdata", 32'(vram_wdata), 32'h04);
        settle();
        ack_dly = 2;

        // Status read clears the first-byte flag
        host_wr(1'b1, 8'h34);
        status_in = 8'h80;
        host_rd(1'b1);
        chk("st_dout", 32'(cpu_dout), 32'h80);
        chk("st_rd_pulse", 32'(status_rd), 32'h1);
        tick();
        chk("st_rd_pulse_end", 32'(status_rd), 32'h0);
        host_wr(1'b1, 8'h00);
        host_wr(1'b1, 8'h40);
        chk("st_no_reg_we", 32'(reg_we), 32'h0);
        chk("st_no_prefetch", 32'(vram_req), 32'h0);
        host_wr(1'b0, 8'h77);
        chk("st_ptr_zero", 32'(vram_addr), 32'h0000);
        settle();

        // Simultaneous rd+wr on data port: write wins, read ignored
        cpu_rd = 1'b1;
        host_wr(1'b0, 8'h99);
        cpu_rd = 1'b0;
        chk("rdwr_is_write", 32'(vram_wr), 32'h1);
        chk("rdwr_addr", 32'(vram_addr), 32'h0001);
        chk("rdwr_wdata", 32'(vram_wdata), 32'h99);
        chk("rdwr_dout_kept", 32'(cpu_dout), 32'h80);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
